// File: rtl/ppcm_arbiter_if.sv
// Bus bundle between the two PCM masters, the arbiter and the shared Parallel PCM core.
// The slave modport is the arbiter's view. The master modport is the surrounding masters' and core's view.
interface ppcm_arbiter_if #(
  parameter int ADDR_BITS = 24
);
  // m_cs_x is a request that is held until m_ack_x or m_err_x. m_busy_x tells master x to wait.
  // m_ack_x is a one-cycle completion pulse, and m_dout is valid only in that cycle.
  logic                 m_cs_0;
  logic                 m_cs_1;
  logic [ADDR_BITS-3:0] m_addr_0;
  logic [ADDR_BITS-3:0] m_addr_1;
  logic                 m_burst_0;
  logic                 m_burst_1;
  logic [31:0]          m_dout;
  logic                 m_busy_0;
  logic                 m_busy_1;
  logic                 m_ack_0;
  logic                 m_ack_1;
  logic                 m_err_0;
  logic                 m_err_1;
  logic                 core_cs;
  logic [ADDR_BITS-3:0] core_addr;
  logic                 core_burst;
  logic [31:0]          core_dout;
  logic                 core_busy;
  logic                 core_ack;

  modport slave (
    input  m_cs_0, m_cs_1, m_addr_0, m_addr_1, m_burst_0, m_burst_1,
    output m_dout, m_busy_0, m_busy_1, m_ack_0, m_ack_1, m_err_0, m_err_1,
    output core_cs, core_addr, core_burst,
    input  core_dout, core_busy, core_ack
  );

  modport master (
    output m_cs_0, m_cs_1, m_addr_0, m_addr_1, m_burst_0, m_burst_1,
    input  m_dout, m_busy_0, m_busy_1, m_ack_0, m_ack_1, m_err_0, m_err_1,
    input  core_cs, core_addr, core_burst,
    output core_dout, core_busy, core_ack
  );
endinterface

// File: rtl/ppcm_arbiter.sv
// Two-master arbiter for one read-only Parallel PCM core, with a grant watchdog.
// PPCM_ARB_RR_EN selects round-robin arbitration; without it, m0 has fixed priority.
module ppcm_arbiter #(
  parameter int ADDR_BITS = 24,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_BITS  = 11
) (
  input  logic               clk,
  input  logic               rst,
  ppcm_arbiter_if.slave      bus,
  output logic [3:0]         state_dbg
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic                sel, sel_nx;
  logic                last, last_nx;
  logic                started, started_nx;
  logic [CNT_BITS-1:0] wdog, wdog_nx;

  logic any_req;
  logic pick;
  logic cs_sel;
  logic granted;
  logic abort;
  logic wd_expire;

  assign any_req = bus.m_cs_0 | bus.m_cs_1;

`ifdef PPCM_ARB_RR_EN
  // On a tie, the master that was not served last wins. A lone requester always wins.
  assign pick = (bus.m_cs_0 & bus.m_cs_1) ? ~last : bus.m_cs_1;
`else
  assign pick = ~bus.m_cs_0;
`endif

  assign cs_sel  = sel ? bus.m_cs_1 : bus.m_cs_0;
  assign granted = (state == S_GRANT);

  // The master withdrew before the core ever went busy, so there is nothing to finish.
  assign abort     = granted & ~started & ~bus.core_busy & ~cs_sel & ~bus.core_ack;
  assign wd_expire = granted & (wdog == CNT_BITS'(TIMEOUT - 1)) & ~bus.core_ack & ~abort;

  assign bus.core_cs    = granted & cs_sel;
  assign bus.core_addr  = sel ? bus.m_addr_1 : bus.m_addr_0;
  assign bus.core_burst = sel ? bus.m_burst_1 : bus.m_burst_0;
  assign bus.m_dout     = bus.core_dout;

  assign bus.m_ack_0 = bus.core_ack & granted & ~sel;
  assign bus.m_ack_1 = bus.core_ack & granted & sel;
  assign bus.m_err_0 = wd_expire & ~sel;
  assign bus.m_err_1 = wd_expire & sel;

  assign bus.m_busy_0 = (bus.core_busy & (state == S_IDLE)) | (granted & sel) |
                        (granted & ~sel & ~bus.m_ack_0);
  assign bus.m_busy_1 = (bus.core_busy & (state == S_IDLE)) | (granted & ~sel) |
                        (granted & sel & ~bus.m_ack_1);

  assign state_dbg = {last, sel, state};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sel     <= 1'b0;
      last    <= 1'b1;
      started <= 1'b0;
      wdog    <= '0;
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      last    <= last_nx;
      started <= started_nx;
      wdog    <= wdog_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    last_nx    = last;
    started_nx = started;
    wdog_nx    = wdog;
    case (state)
      S_IDLE: begin
        started_nx = 1'b0;
        wdog_nx    = '0;
        if (any_req & ~bus.core_busy) begin
          state_nx = S_GRANT;
          sel_nx   = pick;
        end
      end
      S_GRANT: begin
        started_nx = started | bus.core_busy;
        wdog_nx    = wdog + CNT_BITS'(1);
        if (bus.core_ack) begin
          state_nx = S_RELEASE;
          last_nx  = sel;
        end else if (abort) begin
          state_nx = S_RELEASE;
        end else if (wd_expire) begin
          state_nx = S_RELEASE;
          last_nx  = sel;
        end
      end
      // One dead cycle lets the core settle back to idle before the next grant.
      S_RELEASE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ppcm_arbiter.sv
// Directed bench for ppcm_arbiter: a behavioural PCM core, a scoreboard queue for acknowledged reads,
// and step-by-step checks of grant, release, watchdog, abort and reset behaviour.
module tb_ppcm_arbiter;
  localparam int AB = 24;
  localparam int TO = 16;
  localparam int CB = 5;
  localparam int AW = AB - 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dbg;

  ppcm_arbiter_if #(.ADDR_BITS(AB)) bus ();

  ppcm_arbiter #(.ADDR_BITS(AB), .TIMEOUT(TO), .CNT_BITS(CB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (dbg)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [33:0] exp_q[$];
  int          ack_cnt = 0;
  int          err_seen = 0;

  int          lat = 2;
  bit          hang = 1'b0;
  bit          init_busy = 1'b0;
  logic        busy_m = 1'b0;
  logic        ack_m = 1'b0;
  int          cnt = 0;
  logic [31:0] dout_r = '0;

  assign bus.core_busy = init_busy | busy_m;
  assign bus.core_ack  = ack_m;
  assign bus.core_dout = dout_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] core_word(input logic [AW-1:0] a);
    return 32'hDEAD_BEDF + {10'b0, a};
  endfunction

  // Behavioural core: accepts a cs when idle, stays busy for lat cycles, then acks once.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        busy_m = 1'b0;
        ack_m  = 1'b0;
      end else if (ack_m) begin
        ack_m  = 1'b0;
        busy_m = 1'b0;
      end else if (busy_m) begin
        if (cnt == 0) begin
          ack_m  = 1'b1;
          dout_r = core_word(bus.core_addr);
        end else begin
          cnt--;
        end
      end else if (bus.core_cs && !hang && !init_busy) begin
        busy_m = 1'b1;
        cnt    = lat;
      end
    end
  end

  // Scoreboard: every acknowledged read is checked against the oldest expected {ack_1, ack_0, data}.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && (bus.m_ack_0 || bus.m_ack_1)) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {30'b0, bus.m_ack_1, bus.m_ack_0, bus.m_dout}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_data", {30'b0, bus.m_ack_1, bus.m_ack_0, bus.m_dout}, {30'b0, e});
        end
      end
      if (!rst && (bus.m_err_0 || bus.m_err_1)) err_seen++;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.m_cs_0 = 1'b0;
    bus.m_cs_1 = 1'b0;
    bus.m_burst_0 = 1'b0;
    bus.m_burst_1 = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int max);
    int i = 0;
    while (dbg[1:0] !== st && i < max) begin
      cyc();
      i++;
    end
    check(tag, {62'b0, dbg[1:0]}, {62'b0, st});
  endtask

  task automatic wait_ack(input string tag, input int max);
    int n0 = ack_cnt;
    int i  = 0;
    while (ack_cnt == n0 && i < max) begin
      cyc();
      i++;
    end
    check(tag, 64'(ack_cnt - n0), 64'd1);
  endtask

  initial begin
    int gc;
    int err_at;
    bit err1_bad;
    bit busy_all;
    int n0;
    int i;

    bus.m_cs_0 = 1'b0;
    bus.m_cs_1 = 1'b0;
    bus.m_addr_0 = '0;
    bus.m_addr_1 = '0;
    bus.m_burst_0 = 1'b0;
    bus.m_burst_1 = 1'b0;

    // Reset during core initialisation with m0 already requesting.
    init_busy = 1'b1;
    rst = 1'b1;
    bus.m_cs_0 = 1'b1;
    bus.m_addr_0 = 22'h10;
    cyc();
    cyc();
    check("rst_regs", {60'b0, dbg}, {60'b0, 4'b1000});
    check("rst_ack_err", {60'b0, bus.m_ack_1, bus.m_ack_0, bus.m_err_1, bus.m_err_0}, 64'd0);
    check("rst_core_cs", {63'b0, bus.core_cs}, 64'd0);
    check("rst_busy", {62'b0, bus.m_busy_1, bus.m_busy_0}, {62'b0, 2'b11});
    rst = 1'b0;
    repeat (3) cyc();
    check("init_hold", {61'b0, dbg[1:0], bus.core_cs}, {61'b0, ST_IDLE, 1'b0});
    init_busy = 1'b0;
    cyc();
    check("grant_m0", {39'b0, dbg[1:0], bus.core_cs, bus.core_addr}, {39'b0, ST_GRANT, 1'b1, 22'h10});

    // m0 single read completes with DEADBEEF, then two cycles to idle.
    exp_q.push_back({2'b01, 32'hDEAD_BEEF});
    wait_ack("single_ack", 20);
    bus.m_cs_0 = 1'b0;
    cyc();
    check("single_release", {62'b0, dbg[1:0]}, {62'b0, ST_RELEASE});
    cyc();
    check("single_idle", {62'b0, dbg[1:0]}, {62'b0, ST_IDLE});

    // Both masters request continuously for four transactions.
    do_reset();
    bus.m_addr_0 = 22'h10;
    bus.m_addr_1 = 22'h20;
    bus.m_cs_0 = 1'b1;
    bus.m_cs_1 = 1'b1;
`ifdef PPCM_ARB_RR_EN
    exp_q.push_back({2'b01, core_word(22'h10)});
    exp_q.push_back({2'b10, core_word(22'h20)});
    exp_q.push_back({2'b01, core_word(22'h10)});
    exp_q.push_back({2'b10, core_word(22'h20)});
`else
    for (int k = 0; k < 4; k++) exp_q.push_back({2'b01, core_word(22'h10)});
`endif
    for (int k = 0; k < 4; k++) wait_ack("both_ack", 20);
    bus.m_cs_0 = 1'b0;
    bus.m_cs_1 = 1'b0;
    cyc();
    cyc();

    // m1 burst holds the grant while m0 waits; m0 granted three cycles after m1's ack.
    do_reset();
    lat = 6;
    bus.m_addr_1 = 22'h40;
    bus.m_burst_1 = 1'b1;
    bus.m_cs_1 = 1'b1;
    wait_state("burst_grant", ST_GRANT, 5);
    check("burst_route", {40'b0, bus.core_burst, bus.core_addr, dbg[2]}, {40'b0, 1'b1, 22'h40, 1'b1});
    exp_q.push_back({2'b10, core_word(22'h40)});
    exp_q.push_back({2'b01, core_word(22'h10)});
    bus.m_addr_0 = 22'h10;
    bus.m_cs_0 = 1'b1;
    n0 = ack_cnt;
    i = 0;
    busy_all = 1'b1;
    while (ack_cnt == n0 && i < 30) begin
      cyc();
      i++;
      if (bus.m_busy_0 !== 1'b1) busy_all = 1'b0;
    end
    check("burst_ack", 64'(ack_cnt - n0), 64'd1);
    check("busy0_held", {63'b0, busy_all}, 64'd1);
    bus.m_cs_1 = 1'b0;
    bus.m_burst_1 = 1'b0;
    cyc();
    check("burst_rel1", {61'b0, dbg[1:0], bus.core_cs}, {61'b0, ST_RELEASE, 1'b0});
    cyc();
    check("burst_rel2", {62'b0, dbg[1:0]}, {62'b0, ST_IDLE});
    cyc();
    check("m0_after_burst", {39'b0, dbg[2:0], bus.core_addr}, {39'b0, 1'b0, ST_GRANT, 22'h10});
    wait_ack("m0_after_burst_ack", 20);
    bus.m_cs_0 = 1'b0;
    lat = 2;
    cyc();

    // Core never responds: watchdog aborts on the 16th grant cycle.
    do_reset();
    hang = 1'b1;
    bus.m_addr_0 = 22'h10;
    bus.m_cs_0 = 1'b1;
    gc = 0;
    err_at = 0;
    err1_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (dbg[1:0] == ST_GRANT) gc++;
      if (bus.m_err_1) err1_bad = 1'b1;
      if (bus.m_err_0) begin
        err_at = gc;
        break;
      end
    end
    check("wdog_cycle", 64'(err_at), 64'(TO));
    check("wdog_err1", {63'b0, err1_bad}, 64'd0);
    bus.m_cs_0 = 1'b0;
    hang = 1'b0;
    cyc();
    check("wdog_release", {60'b0, dbg[1:0], bus.m_err_1, bus.m_err_0}, {60'b0, ST_RELEASE, 2'b00});
    bus.m_addr_1 = 22'h20;
    bus.m_cs_1 = 1'b1;
    exp_q.push_back({2'b10, core_word(22'h20)});
    wait_ack("after_wdog_ack", 20);
    bus.m_cs_1 = 1'b0;
    cyc();

    // m0 withdraws on its grant cycle before the core starts; m1 is served next.
    do_reset();
    hang = 1'b1;
    bus.m_addr_0 = 22'h10;
    bus.m_addr_1 = 22'h20;
    bus.m_cs_0 = 1'b1;
    bus.m_cs_1 = 1'b1;
    wait_state("abort_grant", ST_GRANT, 5);
    check("abort_sel", {63'b0, dbg[2]}, 64'd0);
    bus.m_cs_0 = 1'b0;
    #1;
    check("abort_no_resp", {60'b0, bus.m_ack_1, bus.m_ack_0, bus.m_err_1, bus.m_err_0}, 64'd0);
    cyc();
    hang = 1'b0;
    check("abort_release", {62'b0, dbg[1:0]}, {62'b0, ST_RELEASE});
    cyc();
    check("abort_idle", {62'b0, dbg[1:0]}, {62'b0, ST_IDLE});
    cyc();
    check("abort_m1_grant", {39'b0, dbg[2:0], bus.core_addr}, {39'b0, 1'b1, ST_GRANT, 22'h20});
    exp_q.push_back({2'b10, core_word(22'h20)});
    wait_ack("abort_m1_ack", 20);
    bus.m_cs_1 = 1'b0;
    cyc();

    // Reset in the middle of a granted read: back to reset values, no response.
    do_reset();
    lat = 8;
    bus.m_addr_0 = 22'h30;
    bus.m_cs_0 = 1'b1;
    wait_state("midrst_grant", ST_GRANT, 5);
    cyc();
    cyc();
    check("midrst_busy", {62'b0, bus.m_busy_1, bus.m_busy_0}, {62'b0, 2'b11});
    rst = 1'b1;
    bus.m_cs_0 = 1'b0;
    cyc();
    check("midrst_regs", {60'b0, dbg}, {60'b0, 4'b1000});
    check("midrst_out", {58'b0, bus.m_ack_1, bus.m_ack_0, bus.m_err_1, bus.m_err_0, bus.core_cs, bus.m_busy_0},
          64'd0);
    rst = 1'b0;
    repeat (12) cyc();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("err_total", 64'(err_seen), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
